// File: rtl/cube_accum.sv
// cube_accum: sums a stream of unsigned cube results into frames of FRAME_LEN
// samples and presents each finished frame sum through a valid/ready holding
// register. The input side is never stalled. A finished frame replaces an
// unaccepted result, and the sticky overrun flag records that.
module cube_accum #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [15:0]       out_count,
    output logic              out_sat,
    output logic              overrun
);

    localparam logic [15:0] FRAME_CNT = 16'(FRAME_LEN);

    // Working frame state
    logic [ACC_W-1:0] acc;
    logic [15:0]      cnt;
    logic             sat_w;

    // Frame state after this cycle's sample (if any) is folded in
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] next_sum;
    logic [15:0]      next_cnt;
    logic             next_sat;
    logic             close;

    // Fold the current sample into the frame, clamp on carry-out, detect frame close
    always_comb begin
        sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
        next_sum = acc;
        next_cnt = cnt;
        next_sat = sat_w;
        if (in_valid) begin
            next_cnt = cnt + 16'd1;
            if (sum_ext[ACC_W]) begin
                // An all-ones accumulator can only carry again or stay equal,
                // so clamping here keeps it pinned until the frame closes.
                next_sum = '1;
                next_sat = 1'b1;
            end else begin
                next_sum = sum_ext[ACC_W-1:0];
            end
        end
        close = (in_valid && (next_cnt == FRAME_CNT)) || (flush && (next_cnt != '0));
    end

    // Working accumulator: advance every cycle, restart when the frame closes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            cnt   <= '0;
            sat_w <= 1'b0;
        end else if (close) begin
            acc   <= '0;
            cnt   <= '0;
            sat_w <= 1'b0;
        end else begin
            acc   <= next_sum;
            cnt   <= next_cnt;
            sat_w <= next_sat;
        end
    end

    // Holding register: a close always loads, otherwise a handshake empties it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= next_sum;
            out_count <= next_cnt;
            out_sat   <= next_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a close landed on a result the sink had not taken
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (close && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cube_accum.sv
// Self-checking bench for cube_accum: directed scenarios plus randomized
// traffic compared against a frame-level arithmetic reference model.
module tb_cube_accum;

    localparam int unsigned FL = 8;
    localparam longint unsigned MAXV = (64'd1 << 48) - 64'd1;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = '0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;

    logic        out_valid;
    logic [47:0] out_sum;
    logic [15:0] out_count;
    logic        out_sat;
    logic        overrun;

    logic        s_valid;
    logic [32:0] s_sum;
    logic [15:0] s_count;
    logic        s_sat;
    logic        s_overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model: running frame total and the held result
    longint unsigned m_acc    = 0;
    int unsigned     m_cnt    = 0;
    bit              m_sat    = 0;
    bit              m_valid  = 0;
    longint unsigned m_osum   = 0;
    int unsigned     m_ocount = 0;
    bit              m_osat   = 0;
    bit              m_ovr    = 0;

    cube_accum #(.DATA_W(32), .ACC_W(48), .FRAME_LEN(FL)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat), .overrun(overrun)
    );

    cube_accum #(.DATA_W(32), .ACC_W(33), .FRAME_LEN(FL)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_valid(s_valid), .out_ready(out_ready),
        .out_sum(s_sum), .out_count(s_count), .out_sat(s_sat), .overrun(s_overrun)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_sat = 0;
        m_valid = 0; m_osum = 0; m_ocount = 0; m_osat = 0; m_ovr = 0;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit f, input bit r);
        in_valid = v; in_data = d; flush = f; out_ready = r;
    endtask

    // One clock edge: update the model from the inputs present at the edge
    task automatic tick();
        longint unsigned nsum;
        bit              nsat;
        int unsigned     ncnt;
        bit              cls;
        @(posedge clock);
        if (reset) begin
            nsum = m_acc + (in_valid ? 64'(in_data) : 64'd0);
            nsat = m_sat;
            if (nsum > MAXV) begin
                nsum = MAXV;
                nsat = 1;
            end
            ncnt = m_cnt + (in_valid ? 1 : 0);
            cls  = (in_valid && ncnt == FL) || (flush && ncnt != 0);
            if (cls) begin
                if (m_valid && !out_ready) m_ovr = 1;
                m_valid = 1; m_osum = nsum; m_ocount = ncnt; m_osat = nsat;
                m_acc = 0; m_cnt = 0; m_sat = 0;
            end else begin
                if (out_ready) m_valid = 0;
                m_acc = nsum; m_cnt = ncnt; m_sat = nsat;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({out_valid, out_sum, out_count, out_sat, overrun} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {out_valid, out_sum, out_count, out_sat, overrun});
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_valid got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_full_frame();
        drive(1, 32'd27, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({out_valid, out_sum, out_count, out_sat, overrun} !== {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr}) begin
                failures++;
                $display("FAIL full_frame_model got=%0h exp=%0h", {out_valid, out_sum, out_count, out_sat, overrun},
                         {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr});
            end
        end
        checks++;
        if ({out_valid, out_sum, out_count, out_sat} !== {1'b1, 48'd216, 16'd8, 1'b0}) begin
            failures++;
            $display("FAIL full_frame_sum got=%0h/%0d/%0b exp=216/8/0", out_sum, out_count, out_sat);
        end
        drive(0, 0, 0, 1);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_frame_drop got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] c;
        for (int k = 1; k <= 8; k++) begin
            c = 32'(k * k * k);
            drive(1, c, 0, 0);
            tick();
            drive(0, 0, 0, 0);
            tick(); tick();
        end
        checks++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 48'd1296, 16'd8}) begin
            failures++;
            $display("FAIL backpressure_sum got=%0b/%0d/%0d exp=1/1296/8", out_valid, out_sum, out_count);
        end
        repeat (4) tick();
        checks++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 48'd1296, 16'd8}) begin
            failures++;
            $display("FAIL backpressure_hold got=%0b/%0d/%0d exp=1/1296/8", out_valid, out_sum, out_count);
        end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_accept got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_flush();
        repeat (3) begin
            drive(1, 32'd1000, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        tick();
        checks++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 48'd3000, 16'd3}) begin
            failures++;
            $display("FAIL flush_alone got=%0b/%0d/%0d exp=1/3000/3", out_valid, out_sum, out_count);
        end
        drive(0, 0, 0, 1);
        tick();
        drive(1, 32'd1, 0, 0);
        tick(); tick();
        drive(1, 32'd5, 1, 0);
        tick();
        checks++;
        if ({out_valid, out_sum, out_count, overrun} !== {1'b1, 48'd7, 16'd3, 1'b0}) begin
            failures++;
            $display("FAIL flush_with_sample got=%0b/%0d/%0d/%0b exp=1/7/3/0", out_valid, out_sum, out_count, overrun);
        end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        checks++;
        if ({out_valid, out_sum, out_count, out_sat, overrun} !== {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr}
            || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got=%0b exp=0", out_valid);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b0;
        #1;
        model_clear();
        tick();
        reset = 1'b1;
        drive(1, 32'hFFFF_FFFF, 0, 1);
        repeat (8) tick();
        checks++;
        if ({s_valid, s_sum, s_count, s_sat} !== {1'b1, 33'h1_FFFF_FFFF, 16'd8, 1'b1}) begin
            failures++;
            $display("FAIL sat_clamp got=%0b/%0h/%0d/%0b exp=1/1ffffffff/8/1", s_valid, s_sum, s_count, s_sat);
        end
        checks++;
        if ({out_valid, out_sum, out_count, out_sat} !== {m_valid, m_osum[47:0], m_ocount[15:0], m_osat}) begin
            failures++;
            $display("FAIL sat_wide_nosat got=%0h/%0b exp=%0h/%0b", out_sum, out_sat, m_osum, m_osat);
        end
        drive(1, 32'd1, 0, 1);
        repeat (8) tick();
        checks++;
        if ({s_valid, s_sum, s_count, s_sat} !== {1'b1, 33'd8, 16'd8, 1'b0}) begin
            failures++;
            $display("FAIL sat_next_frame got=%0b/%0h/%0d/%0b exp=1/8/8/0", s_valid, s_sum, s_count, s_sat);
        end
        drive(0, 0, 0, 1);
        tick();
    endtask

    task automatic test_overrun();
        longint unsigned sum1;
        longint unsigned sum2;
        logic [31:0]     d;
        sum1 = 0;
        sum2 = 0;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            if (i < 8) sum1 += 64'(d); else sum2 += 64'(d);
            drive(1, d, 0, 0);
            tick();
            if (i == 7) begin
                checks++;
                if ({out_valid, out_sum, overrun} !== {1'b1, sum1[47:0], 1'b0}) begin
                    failures++;
                    $display("FAIL overrun_first got=%0b/%0h/%0b exp=1/%0h/0", out_valid, out_sum, overrun, sum1);
                end
            end
        end
        checks++;
        if ({out_valid, out_sum, out_count, overrun} !== {1'b1, sum2[47:0], 16'd8, 1'b1}) begin
            failures++;
            $display("FAIL overrun_second got=%0b/%0h/%0d/%0b exp=1/%0h/8/1", out_valid, out_sum, out_count, overrun, sum2);
        end
        drive(0, 0, 0, 1);
        tick();
        tick();
        checks++;
        if ({out_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL overrun_sticky got=%0b/%0b exp=0/1", out_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'd3, 0, 0);
        repeat (8) tick();
        drive(1, 32'd9, 0, 0);
        repeat (5) tick();
        checks++;
        if ({out_valid, out_sum} !== {1'b1, 48'd24}) begin
            failures++;
            $display("FAIL reset_mid_setup got=%0b/%0d exp=1/24", out_valid, out_sum);
        end
        drive(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({out_valid, out_sum, out_count, out_sat, overrun} !== 67'd0) begin
            failures++;
            $display("FAIL reset_mid_async got=%0h exp=0", {out_valid, out_sum, out_count, out_sat, overrun});
        end
        tick(); tick();
        reset = 1'b1;
        drive(1, 32'd2, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({out_valid, out_sum, out_count, out_sat, overrun} !== {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr}) begin
                failures++;
                $display("FAIL reset_mid_resume got=%0h exp=%0h", {out_valid, out_sum, out_count, out_sat, overrun},
                         {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr});
            end
        end
        checks++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 48'd16, 16'd8}) begin
            failures++;
            $display("FAIL reset_mid_sum got=%0b/%0d/%0d exp=1/16/8", out_valid, out_sum, out_count);
        end
        drive(0, 0, 0, 1);
        tick();
    endtask

    task automatic test_back_to_back();
        bit          v;
        bit          f;
        bit          r;
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, d, f, r);
            tick();
            checks++;
            if ({out_valid, out_sum, out_count, out_sat, overrun} !== {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr}) begin
                failures++;
                $display("FAIL random_cycle%0d got=%0h exp=%0h", i, {out_valid, out_sum, out_count, out_sat, overrun},
                         {m_valid, m_osum[47:0], m_ocount[15:0], m_osat, m_ovr});
            end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_flush();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
